// File: rtl/dmem_responder_if.sv
// Valid/ready request/response bundle between a CPU MEM stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADR_W-1:0]  req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_wr,
        output req_adr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_adr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a programmable number of wait
// states between request accept and response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                wr_q;
    logic                wr_d;
    logic [ADR_W-1:0]    adr_q;
    logic [ADR_W-1:0]    adr_d;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wdata_d;
    logic                ready_q;
    logic                ready_d;
    logic                rsp_valid_q;
    logic                rsp_valid_d;
    logic                rsp_err_q;
    logic                rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   rsp_rdata_d;

    logic                accept;
    logic                rsp_done;
    logic                enter_resp;
    logic                acc_wr;
    logic [ADR_W-1:0]    acc_adr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_err;
    logic                mem_we;

    // Storage is not touched by reset; it starts out all zero.
    logic [DATA_W-1:0]   mem [DEPTH_WORDS] = '{default: '0};

    // Reset overrides ready so a request presented alongside rst is never taken.
    assign accept   = bus.req_valid && ready_q && !rst;
    assign rsp_done = (state_q == ST_RESP) && rsp_valid_q && bus.rsp_ready;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request fields are used instead of the latched copies.
    always_comb begin
        acc_wr    = wr_q;
        acc_adr   = adr_q;
        acc_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_wr    = bus.req_wr;
            acc_adr   = bus.req_adr;
            acc_wdata = bus.req_wdata;
        end
    end

    // Range test uses the full word address so large addresses never alias.
    assign acc_idx = acc_adr[IDX_W+1:2];
    assign acc_err = (acc_adr[1:0] != 2'b00) ||
                     (32'(acc_adr[ADR_W-1:2]) >= 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == ST_RESP) && (state_q != ST_RESP);
    assign mem_we     = enter_resp && acc_wr && !acc_err && !rst;

    // Next values for the request latch, wait counter and response registers.
    always_comb begin
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        ready_d     = (state_nxt == ST_IDLE);
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            wr_d    = bus.req_wr;
            adr_d   = bus.req_adr;
            wdata_d = bus.req_wdata;
            cnt_d   = CNT_W'(WAIT_CYCLES);
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_wr || acc_err) ? '0 : mem[acc_idx];
        end else if (rsp_done) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Read data is taken from the combinational read before this write lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = ready_q && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/abort sequences,
// randomized traffic against an array model, and a zero-wait-state instance.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned W2    = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          stall;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] ref_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a word array with alignment and bounds rules applied directly.
    task automatic model_access(input logic wr, input logic [31:0] adr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
        err   = (adr % 4 != 0) || ((adr / 4) >= DEPTH);
        rdata = 32'h0;
        if (!err) begin
            if (wr) ref_mem[adr / 4] = wdata;
            else    rdata = ref_mem[adr / 4];
        end
    endtask

    // One transaction on the 2-wait-state instance; request fields are
    // scrambled right after accept to show they are no longer looked at.
    task automatic txn(input logic wr, input logic [31:0] adr, input logic [31:0] wdata,
                       input int stall, output logic err, output logic [31:0] rdata);
        int n;
        int lat;
        n = 0;
        while (bus2.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready idle", 32'(bus2.req_ready), 32'h1);
        bus2.req_valid = 1'b1;
        bus2.req_wr    = wr;
        bus2.req_adr   = adr;
        bus2.req_wdata = wdata;
        bus2.rsp_ready = (stall == 0);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        bus2.req_wr    = 1'($urandom);
        bus2.req_adr   = $urandom;
        bus2.req_wdata = $urandom;
        lat = 1;
        while (bus2.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(W2 + 1));
        chk("req_ready in resp", 32'(bus2.req_ready), 32'h0);
        err   = bus2.rsp_err;
        rdata = bus2.rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold valid", 32'(bus2.rsp_valid), 32'h1);
            chk("hold rdata", bus2.rsp_rdata, rdata);
            chk("hold err", 32'(bus2.rsp_err), 32'(err));
            chk("hold req_ready", 32'(bus2.req_ready), 32'h0);
        end
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        chk("post valid", 32'(bus2.rsp_valid), 32'h0);
        chk("post rdata", bus2.rsp_rdata, 32'h0);
        chk("post err", 32'(bus2.rsp_err), 32'h0);
        chk("post req_ready", 32'(bus2.req_ready), 32'h1);
        bus2.rsp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        logic        err;
        logic [31:0] rdata;
        logic        e_err;
        logic [31:0] e_rdata;

        vecs = '{
            '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000},
            '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF},
            '{1'b0, 32'h0000_0012, 32'h0000_0000, 0, 1'b1, 32'h0000_0000},
            '{1'b1, 32'h0000_0400, 32'h1234_5678, 0, 1'b1, 32'h0000_0000},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1, 1'b0, 32'h0000_0000},
            '{1'b0, 32'h0000_0010, 32'h0000_0000, 5, 1'b0, 32'hDEAD_BEEF},
            '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0000},
            '{1'b0, 32'h0000_03FC, 32'h0000_0000, 0, 1'b0, 32'hCAFE_F00D},
            '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 1'b1, 32'h0000_0000},
            '{1'b0, 32'h1000_0000, 32'h0000_0000, 3, 1'b1, 32'h0000_0000},
            '{1'b1, 32'h0000_0011, 32'h7777_7777, 0, 1'b1, 32'h0000_0000},
            '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF}
        };
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;

        rst = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_wr = 1'b0; bus2.req_adr = '0; bus2.req_wdata = '0;
        bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_wr = 1'b0; bus0.req_adr = '0; bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(bus2.req_ready), 32'h0);
        chk("reset rsp_valid", 32'(bus2.rsp_valid), 32'h0);
        chk("reset rsp_rdata", bus2.rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(bus2.rsp_err), 32'h0);
        chk("reset w0 req_ready", 32'(bus0.req_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("after reset req_ready", 32'(bus2.req_ready), 32'h1);
        chk("after reset w0 req_ready", 32'(bus0.req_ready), 32'h1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            model_access(vecs[i].wr, vecs[i].adr, vecs[i].wdata, e_err, e_rdata);
            txn(vecs[i].wr, vecs[i].adr, vecs[i].wdata, vecs[i].stall, err, rdata);
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Reset during WAIT discards a pending store
        bus2.req_valid = 1'b1; bus2.req_wr = 1'b1;
        bus2.req_adr = 32'h20; bus2.req_wdata = 32'h55;
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort rsp_valid", 32'(bus2.rsp_valid), 32'h0);
        chk("abort req_ready", 32'(bus2.req_ready), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no rsp after abort", 32'(bus2.rsp_valid), 32'h0);
        end
        bus2.rsp_ready = 1'b0;
        model_access(1'b0, 32'h20, 32'h0, e_err, e_rdata);
        txn(1'b0, 32'h20, 32'h0, 0, err, rdata);
        chk("abort readback", rdata, e_rdata);
        chk("abort readback value", rdata, 32'h0);

        // Reset wins over a simultaneous request
        rst = 1'b1;
        bus2.req_valid = 1'b1; bus2.req_wr = 1'b0; bus2.req_adr = 32'h10;
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst+valid req_ready", 32'(bus2.req_ready), 32'h0);
        rst = 1'b0;
        bus2.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst+valid no rsp", 32'(bus2.rsp_valid), 32'h0);
        end
        bus2.rsp_ready = 1'b0;

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            int          r;
            logic        wr;
            logic [31:0] adr;
            logic [31:0] wd;
            r  = int'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (r < 6)       adr = 32'($urandom_range(0, 15)) << 2;
            else if (r == 6) adr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) adr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else             adr = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            model_access(wr, adr, wd, e_err, e_rdata);
            txn(wr, adr, wd, int'($urandom_range(0, 3)), err, rdata);
            chk("rand err", 32'(err), 32'(e_err));
            chk("rand rdata", rdata, e_rdata);
        end

        // Zero wait states, req_valid held high
        begin
            logic        wr5 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
            logic [31:0] adr5[4] = '{32'h8, 32'h8, 32'h4, 32'h8};
            logic [31:0] wd5 [4] = '{32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0};
            logic [31:0] exp5[4] = '{32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5};
            int          acc [4];
            int          k;
            int          kr;
            bit          pend;
            k = 0; kr = 0; pend = 1'b0;
            bus0.rsp_ready = 1'b1;
            bus0.req_valid = 1'b1;
            bus0.req_wr = wr5[0]; bus0.req_adr = adr5[0]; bus0.req_wdata = wd5[0];
            for (int cyc = 0; cyc < 30 && kr < 4; cyc++) begin
                @(negedge clk);
                if (pend) begin
                    pend = 1'b0;
                    k++;
                    if (k < 4) begin
                        bus0.req_wr = wr5[k]; bus0.req_adr = adr5[k]; bus0.req_wdata = wd5[k];
                    end else begin
                        bus0.req_valid = 1'b0;
                    end
                end
                if (bus0.rsp_valid === 1'b1 && kr < k) begin
                    chk($sformatf("w0 rdata%0d", kr), bus0.rsp_rdata, exp5[kr]);
                    chk($sformatf("w0 latency%0d", kr), 32'(cyc - acc[kr]), 32'h1);
                    kr++;
                end
                if (bus0.req_valid && bus0.req_ready === 1'b1 && k < 4) begin
                    acc[k] = cyc;
                    if (k > 0) chk($sformatf("w0 spacing%0d", k), 32'(cyc - acc[k-1]), 32'h2);
                    pend = 1'b1;
                end
            end
            chk("w0 responses", 32'(kr), 32'h4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
